// File: rtl/event_scheduler.sv
// rtl/event_scheduler.sv - timestamps input events and periodic deadlines into a FWFT queue
// Optional feature macro: SCHED_PERIODIC_EN (periodic deadline counter)
module event_scheduler #(
    parameter int DATA_W = 64,
    parameter int TS_W   = 64,
    parameter int PERIOD = 1000,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic [DATA_W-1:0] input_0,
    input  logic [DATA_W-1:0] input_1,
    input  logic              new_input_0,
    input  logic              new_input_1,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [TS_W-1:0]   ev_tag,
    output logic [DATA_W-1:0] ev_data_0,
    output logic [DATA_W-1:0] ev_data_1,
    output logic [1:0]        ev_new,
    output logic              ev_periodic,
    output logic              q_push,
    output logic              q_pop,
    output logic              q_push_valid,
    output logic              q_pop_valid,
    output logic [15:0]       drop_cnt,
    output logic              draining
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = TS_W + 2 * DATA_W + 3;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [15:0]       drop_q, drop_d;
    logic              q_push_q, q_push_d, q_pop_q, q_pop_d;
    logic              q_push_valid_q, q_push_valid_d, q_pop_valid_q, q_pop_valid_d;

    logic deadline, empty, full, form, pop, push_try, push_ok, drop, to_run;
    logic [ENT_W-1:0] entry, head;

`ifdef SCHED_PERIODIC_EN
    localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    logic [PW-1:0] per_q, per_d;

    assign deadline = (per_q == PW'(PERIOD - 1));

    always_comb begin
        per_d = per_q;
        if (to_run)
            per_d = '0;
        else if (en)
            per_d = deadline ? '0 : per_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) per_q <= '0;
        else     per_q <= per_d;
    end
`else
    assign deadline = 1'b0;
`endif

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW + 1)'(DEPTH));
    assign form     = en & (new_input_0 | new_input_1 | deadline);
    assign pop      = en & ev_ready & ~empty;
    assign push_try = form & (state_q == ST_RUN);
    // A full queue still takes the entry when the head leaves on the same edge
    assign push_ok  = push_try & (~full | pop);
    assign drop     = form & ~push_ok;
    assign to_run   = en & (state_q == ST_DRAIN) & empty;

    assign entry = {ts_q,
                    new_input_1 ? input_1 : {DATA_W{1'b0}},
                    new_input_0 ? input_0 : {DATA_W{1'b0}},
                    new_input_1, new_input_0, deadline};

    always_comb begin
        state_d        = state_q;
        ts_d           = ts_q;
        cnt_d          = cnt_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        wr_d           = wr_q;
        rd_d           = rd_q;
        mem_d          = mem_q;
        drop_d         = drop_q;
        q_push_d       = push_try;
        q_push_valid_d = push_ok;
        q_pop_d        = pop;
        q_pop_valid_d  = pop;
        if (en)
            ts_d = ts_q + TS_W'(1);
        if (push_ok) begin
            mem_d[wr_q] = entry;
            wr_d        = wr_q + AW'(1);
        end
        if (pop)
            rd_d = rd_q + AW'(1);
        if (drop && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
        if (en && state_q == ST_RUN && flush)
            state_d = ST_DRAIN;
        else if (to_run)
            state_d = ST_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            ts_q           <= '0;
            cnt_q          <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            drop_q         <= '0;
            q_push_q       <= 1'b0;
            q_push_valid_q <= 1'b0;
            q_pop_q        <= 1'b0;
            q_pop_valid_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            ts_q           <= ts_d;
            cnt_q          <= cnt_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            drop_q         <= drop_d;
            q_push_q       <= q_push_d;
            q_push_valid_q <= q_push_valid_d;
            q_pop_q        <= q_pop_d;
            q_pop_valid_q  <= q_pop_valid_d;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= mem_d[i];
        end
    end

    // Head fields read as zero while the queue is empty
    assign head      = empty ? '0 : mem_q[rd_q];
    assign ev_valid  = ~empty;
    assign ev_tag    = head[3 + 2 * DATA_W +: TS_W];
    assign ev_data_1 = head[3 + DATA_W +: DATA_W];
    assign ev_data_0 = head[3 +: DATA_W];
    assign ev_new    = head[2:1];
`ifdef SCHED_PERIODIC_EN
    assign ev_periodic = head[0];
`else
    assign ev_periodic = 1'b0;
`endif

    assign q_push       = q_push_q;
    assign q_pop        = q_pop_q;
    assign q_push_valid = q_push_valid_q;
    assign q_pop_valid  = q_pop_valid_q;
    assign drop_cnt     = drop_q;
    assign draining     = (state_q == ST_DRAIN);
endmodule

// File: tb/tb_event_scheduler.sv
// tb/tb_event_scheduler.sv - directed scoreboard bench for event_scheduler
module tb_event_scheduler;
    localparam int PERIOD = 1000;
    localparam int DEPTH  = 4;
`ifdef SCHED_PERIODIC_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, flush, new_input_0, new_input_1, ev_ready;
    logic [63:0] input_0, input_1;
    logic        ev_valid, ev_periodic, q_push, q_pop, q_push_valid, q_pop_valid, draining;
    logic [63:0] ev_tag, ev_data_0, ev_data_1;
    logic [1:0]  ev_new;
    logic [15:0] drop_cnt;

    event_scheduler #(.DATA_W(64), .TS_W(64), .PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .input_0(input_0), .input_1(input_1),
        .new_input_0(new_input_0), .new_input_1(new_input_1),
        .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_tag(ev_tag),
        .ev_data_0(ev_data_0), .ev_data_1(ev_data_1), .ev_new(ev_new),
        .ev_periodic(ev_periodic), .q_push(q_push), .q_pop(q_pop),
        .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
        .drop_cnt(drop_cnt), .draining(draining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] tag;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [1:0]  nw;
        logic        per;
    } ent_t;

    ent_t        sb[$];
    logic [63:0] m_ts;
    int          m_per;
    bit          m_drain;
    int          m_drop;
    bit          x_push, x_push_ok, x_pop;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ts = '0; m_per = 0; m_drain = 0; m_drop = 0;
        x_push = 0; x_push_ok = 0; x_pop = 0;
    endtask

    task automatic compare_all();
        chk("ev_valid", 64'(ev_valid), 64'(sb.size() > 0));
        if (sb.size() > 0) begin
            chk("ev_tag", ev_tag, sb[0].tag);
            chk("ev_data_0", ev_data_0, sb[0].d0);
            chk("ev_data_1", ev_data_1, sb[0].d1);
            chk("ev_new", 64'(ev_new), 64'(sb[0].nw));
            chk("ev_periodic", 64'(ev_periodic), 64'(sb[0].per));
        end
        chk("q_push", 64'(q_push), 64'(x_push));
        chk("q_push_valid", 64'(q_push_valid), 64'(x_push_ok));
        chk("q_pop", 64'(q_pop), 64'(x_pop));
        chk("q_pop_valid", 64'(q_pop_valid), 64'(x_pop));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("draining", 64'(draining), 64'(m_drain));
    endtask

    // One clock edge: predict from pre-edge model state, then compare after the edge
    task automatic tick();
        bit   dl, form, pop, ptry, pok, drop, to_run;
        ent_t e;
        dl     = PER_EN && (m_per == PERIOD - 1);
        form   = en && (new_input_0 || new_input_1 || dl);
        pop    = en && ev_ready && (sb.size() > 0);
        ptry   = form && !m_drain;
        pok    = ptry && ((sb.size() < DEPTH) || pop);
        drop   = form && !pok;
        to_run = en && m_drain && (sb.size() == 0);
        e.tag  = m_ts;
        e.d0   = new_input_0 ? input_0 : 64'd0;
        e.d1   = new_input_1 ? input_1 : 64'd0;
        e.nw   = {new_input_1, new_input_0};
        e.per  = dl;
        @(posedge clk);
        #1;
        if (pop) void'(sb.pop_front());
        if (pok) sb.push_back(e);
        if (drop && m_drop != 16'hFFFF) m_drop++;
        if (en) begin
            m_ts++;
            m_per = (to_run || dl) ? 0 : m_per + 1;
            if (!m_drain && flush) m_drain = 1;
            else if (to_run)       m_drain = 0;
        end
        x_push = ptry; x_push_ok = pok; x_pop = pop;
        compare_all();
    endtask

    task automatic idle_inputs();
        new_input_0 = 0; new_input_1 = 0; flush = 0;
    endtask

    initial begin
        int          n;
        logic [63:0] held_ts;
        rst = 1; en = 1; flush = 0; ev_ready = 1;
        new_input_0 = 1; new_input_1 = 0; input_0 = 64'd3; input_1 = 64'd0;
        model_reset();
        #2;
        compare_all();
        chk("rst_tag", ev_tag, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk("rst_data0", ev_data_0, 64'd0);
        @(negedge clk);
        rst = 0;
        idle_inputs();

        // Single event at ts 10
        while (m_ts != 64'd10) tick();
        new_input_0 = 1; input_0 = 64'd5;
        tick();
        idle_inputs();
        chk("single_valid", 64'(ev_valid), 64'd1);
        chk("single_tag", ev_tag, 64'd10);
        chk("single_new", 64'(ev_new), 64'b01);
        chk("single_d0", ev_data_0, 64'd5);
        chk("single_d1", ev_data_1, 64'd0);

        // Input coinciding with the first deadline merges into one entry
        while (m_ts != 64'd999) tick();
        new_input_1 = 1; input_1 = 64'd7;
        tick();
        idle_inputs();
        chk("merge_push", 64'(q_push), 64'd1);
        chk("merge_tag", ev_tag, 64'd999);
        chk("merge_new", 64'(ev_new), 64'b10);
        chk("merge_per", 64'(ev_periodic), 64'(PER_EN));
        chk("merge_d1", ev_data_1, 64'd7);
        tick();
        chk("merge_single", 64'(ev_valid), 64'd0);

        while (m_ts != 64'd1999) tick();
        tick();
        chk("dl2_valid", 64'(ev_valid), 64'(PER_EN));
        chk("dl2_tag", ev_valid ? ev_tag : 64'd0, PER_EN ? 64'd1999 : 64'd0);
        repeat (2) tick();

        // Overflow, then a push into a full queue with a simultaneous pop
        ev_ready = 0;
        for (int i = 0; i < 6; i++) begin
            new_input_0 = 1; input_0 = 64'(100 + i);
            tick();
            chk("ovf_push_valid", 64'(q_push_valid), 64'(i < 4));
        end
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        ev_ready = 1; input_0 = 64'd200;
        tick();
        idle_inputs();
        chk("full_pop_accept", 64'(q_push_valid), 64'd1);
        chk("full_pop_drop", 64'(drop_cnt), 64'd2);
        chk("full_pop_head", ev_data_0, 64'd101);
        repeat (6) tick();

        // Flush with three entries queued, inputs during drain are dropped
        ev_ready = 0;
        for (int i = 0; i < 3; i++) begin
            new_input_1 = 1; input_1 = 64'(300 + i);
            tick();
        end
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
        chk("flush_draining", 64'(draining), 64'd1);
        new_input_0 = 1; input_0 = 64'd400;
        repeat (2) tick();
        idle_inputs();
        chk("drain_drop", 64'(drop_cnt), 64'd4);
        ev_ready = 1;
        n = 0;
        while (draining && n < 20) begin
            tick();
            n++;
        end
        chk("drain_exit", 64'(draining), 64'd0);
        n = 0;
        for (int i = 1; i <= PERIOD + 5; i++) begin
            tick();
            if (ev_valid && ev_periodic && n == 0) n = i;
        end
        chk("post_drain_period", 64'(n), PER_EN ? 64'(PERIOD) : 64'd0);

        // Enable freeze with an entry parked at the head
        ev_ready = 0;
        new_input_0 = 1; input_0 = 64'd55;
        tick();
        idle_inputs();
        held_ts = m_ts;
        en = 0; ev_ready = 1;
        for (int i = 0; i < 50; i++) begin
            new_input_1 = i[0]; input_1 = 64'(i);
            tick();
        end
        idle_inputs();
        chk("freeze_valid", 64'(ev_valid), 64'd1);
        chk("freeze_push", 64'(q_push), 64'd0);
        en = 1;
        tick();
        new_input_1 = 1; input_1 = 64'd66;
        tick();
        idle_inputs();
        chk("resume_tag", ev_tag, held_ts + 64'd1);
        repeat (PERIOD) tick();

        // Asynchronous reset mid-run empties the queue at once
        ev_ready = 0;
        new_input_0 = 1; input_0 = 64'd77;
        repeat (2) tick();
        idle_inputs();
        #2;
        rst = 1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 0;
        ev_ready = 1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
